// File: rtl/adder27_pkg.sv
// Shared definitions for the 3+3+cin adder slice.
//   OP_W      : operand width
//   SUM_W     : sum width (OP_W+1, carry-out included)
//   operands_t: packed operand bundle {a, b, cin}
//   sum_t     : sum type
//   ref_sum   : arithmetic reference for a + b + cin
package adder27_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SUM_W = OP_W + 1;

    typedef logic [SUM_W-1:0] sum_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            cin;
    } operands_t;

    // Zero-extend every term to the sum width before adding.
    function automatic sum_t ref_sum(input logic [OP_W-1:0] a,
                                     input logic [OP_W-1:0] b,
                                     input logic            cin);
        return SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
    endfunction

endpackage

// File: rtl/adder27_core.sv
// Purely combinational ripple-carry adder: sum = a + b + cin.
//   ops : operand bundle {a, b, cin}
//   sum : OP_W+1 bit result, MSB is the carry-out
module adder27_core
    import adder27_pkg::*;
(
    input  operands_t ops,
    output sum_t      sum
);

    logic [OP_W:0] carry;

    // One full adder per bit; final carry becomes the sum MSB.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = ops.cin;
        for (int unsigned i = 0; i < OP_W; i++) begin
            sum[i]       = ops.a[i] ^ ops.b[i] ^ carry[i];
            carry[i + 1] = (ops.a[i] & ops.b[i]) | (carry[i] & (ops.a[i] ^ ops.b[i]));
        end
        sum[OP_W] = carry[OP_W];
    end

endmodule

// File: rtl/adder27_slice.sv
// Registered 3-bit + 3-bit + carry-in adder slice, one cycle latency.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid         : qualifies pi6..pi0 this cycle
//   pi6..pi4         : operand A (pi6 = MSB)
//   pi3..pi1         : operand B (pi3 = MSB)
//   pi0              : carry-in
//   po3..po0         : registered sum (po3 = carry-out)
//   out_valid        : po3..po0 hold a result from a valid input
module adder27_slice
    import adder27_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic pi6,
    input  logic pi5,
    input  logic pi4,
    input  logic pi3,
    input  logic pi2,
    input  logic pi1,
    input  logic pi0,
    output logic po3,
    output logic po2,
    output logic po1,
    output logic po0,
    output logic out_valid
);

    operands_t ops_c;
    sum_t      sum_c;
    sum_t      sum_q;
    logic      valid_q;

    // Pin-to-operand mapping: {a[2:0], b[2:0], cin}.
    assign ops_c = {pi6, pi5, pi4, pi3, pi2, pi1, pi0};

    adder27_core u_core (
        .ops (ops_c),
        .sum (sum_c)
    );

    // Sum only loads on valid input, so invalid (possibly X) pins never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q <= sum_c;
            end
        end
    end

    assign po3       = sum_q[3];
    assign po2       = sum_q[2];
    assign po1       = sum_q[1];
    assign po0       = sum_q[0];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder27_slice.sv
// Self-checking bench for adder27_slice: directed and random stimulus
// against an integer-arithmetic model of the registered adder.
module tb_adder27_slice;
    import adder27_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic pi6 = 1'b0, pi5 = 1'b0, pi4 = 1'b0, pi3 = 1'b0, pi2 = 1'b0, pi1 = 1'b0, pi0 = 1'b0;
    logic po3, po2, po1, po0, out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the outputs should show after the latest edge.
    int   exp_po    = 0;
    logic exp_valid = 1'b0;

    adder27_slice dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pi6       (pi6),
        .pi5       (pi5),
        .pi4       (pi4),
        .pi3       (pi3),
        .pi2       (pi2),
        .pi1       (pi1),
        .pi0       (pi0),
        .po3       (po3),
        .po2       (po2),
        .po1       (po1),
        .po0       (po0),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic int model_sum(input logic [6:0] code);
        int a, b, c;
        a = int'(code[6:4]);
        b = int'(code[3:1]);
        c = int'(code[0]);
        return a + b + c;
    endfunction

    function automatic int po_val();
        logic [3:0] v;
        v = {po3, po2, po1, po0};
        return int'(v);
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_po"}, po_val(), exp_po);
        check({tag, "_valid"}, int'(out_valid), int'(exp_valid));
    endtask

    // Present one input, let one edge pass, update model, settle to sample point.
    task automatic step(input logic v, input logic [6:0] code);
        in_valid = v;
        {pi6, pi5, pi4, pi3, pi2, pi1, pi0} = code;
        @(posedge clk);
        if (rst_n) begin
            if (v) exp_po = model_sum(code);
            exp_valid = v;
        end else begin
            exp_po    = 0;
            exp_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [6:0] code;
        sum_t       pkg_val;

        // Reset held from time 0.
        @(posedge clk); #1;
        check("reset_held_po", po_val(), 0);
        check("reset_held_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs("post_release_idle");

        // Zero and max.
        step(1'b1, 7'b0000000); check_outputs("zero");
        step(1'b1, 7'b1111111); check_outputs("max");
        check("max_value", po_val(), 15);

        // Carry ripple cases.
        step(1'b1, 7'b0010001); check_outputs("ripple_1p0p1");
        check("ripple_1p0p1_value", po_val(), 2);
        step(1'b1, 7'b1110000); check_outputs("ripple_7p0p0");
        check("ripple_7p0p0_value", po_val(), 7);
        step(1'b1, 7'b1110001); check_outputs("ripple_7p0p1");
        check("ripple_7p0p1_value", po_val(), 8);

        // Async reset mid-cycle with po = 1011 (7+3+1).
        step(1'b1, 7'b1110111);
        check("pre_reset_value", po_val(), 11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_po", po_val(), 0);
        check("async_reset_valid", int'(out_valid), 0);
        exp_po = 0; exp_valid = 1'b0;
        step(1'b1, 7'b1111111); check_outputs("reset_held_clocked");
        @(negedge clk);
        rst_n = 1'b1;
        #4;

        // Exhaustive back-to-back.
        for (int i = 0; i < 128; i++) begin
            code = 7'(i);
            step(1'b1, code);
            check_outputs("exhaustive");
            pkg_val = ref_sum(code[6:4], code[3:1], code[0]);
            check("pkg_ref", int'(pkg_val), model_sum(code));
        end

        // Hold: po = 0101 then three invalid cycles with random pins.
        step(1'b1, 7'b0110011);
        check("hold_setup_value", po_val(), 5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 7'($urandom_range(0, 127)));
            check("hold_po", po_val(), 5);
            check("hold_valid", int'(out_valid), 0);
        end

        // Reset pulsed during a valid burst.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 7'($urandom_range(0, 127)));
            check_outputs("burst_pre");
        end
        #1 rst_n = 1'b0;
        #1;
        check("burst_reset_po", po_val(), 0);
        check("burst_reset_valid", int'(out_valid), 0);
        exp_po = 0; exp_valid = 1'b0;
        step(1'b1, 7'($urandom_range(0, 127))); check_outputs("burst_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        code = 7'($urandom_range(0, 127));
        step(1'b1, code);
        check_outputs("first_after_release");
        check("first_after_release_value", po_val(), model_sum(code));

        // Random mix of valid and idle cycles.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
            check_outputs("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder27_slice.md
Name: adder27_slice

Overview:
- Registered 3-bit + 3-bit + carry-in adder slice, a partition of a wider approximate-logic adder flow.
- Seven scalar input bits are presented each cycle; the 4-bit sum appears one clock later with a valid flag.
- Sits between partition input registers and the recombination logic; purely arithmetic, no handshake back-pressure.

Parameters:
- OP_W, 3, operand width; sum width is OP_W+1. Only 3 is required and verified.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies pi6..pi0 in the current cycle.
- pi6  input  1  operand A bit 2 (MSB).
- pi5  input  1  operand A bit 1.
- pi4  input  1  operand A bit 0.
- pi3  input  1  operand B bit 2 (MSB).
- pi2  input  1  operand B bit 1.
- pi1  input  1  operand B bit 0.
- pi0  input  1  carry-in.
- po3  output  1  sum bit 3 (carry-out).
- po2  output  1  sum bit 2.
- po1  output  1  sum bit 1.
- po0  output  1  sum bit 0 (LSB).
- out_valid  output  1  po3..po0 hold a result computed from a valid input.

Behaviour:
- Combinational core: S[3:0] = {pi6,pi5,pi4} + {pi3,pi2,pi1} + pi0, unsigned, zero-extended to 4 bits before addition.
- Range 0..15; never overflows 4 bits (max 7+7+1=15).
- Exact arithmetic; no approximation in this block.
- Latency exactly 1 clock. On each rising clk with in_valid=1: {po3..po0} <= S, out_valid <= 1.
- With in_valid=0: out_valid <= 0; po3..po0 hold their previous value.
- Throughput one result per cycle; back-to-back valid inputs give back-to-back results.
- Reset (rst_n=0, asynchronous assert): po3..po0 = 0 and out_valid = 0 immediately, independent of clk. Held while rst_n=0.
- Reset release: synchronous to clk. The first capture occurs on the first rising edge after rst_n=1.
- Reset asserted mid-stream discards any in-flight result; no stale output after release.
- X or Z on input bits while in_valid=0 must not propagate to outputs.

Decomposition:
- Shared package adder27_pkg holds:
  - OP_W = 3
  - SUM_W = OP_W+1
  - a typedef for the 4-bit sum
  - a reference function for a+b+cin, used by the bench
- One sub-module, adder27_core: purely combinational a, b, cin -> sum.
- The top module adds the input mapping, output register and valid register.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with prior po=1011 -> po=0000 and out_valid=0 immediately, before the next clk edge.
- Zero and max: pi=0000000 -> po=0000; pi=1111111 (7+7+1) -> po=1111; both one cycle after in_valid.
- Carry ripple: pi=0010001 (1+0+1) -> po=0010; pi=1110000 (7+0+0) -> po=0111; pi=1110001 (7+0+1) -> po=1000.
- Exhaustive: all 128 input codes with in_valid=1 back-to-back -> each po equals the package reference, one cycle later, out_valid continuously 1.
- Hold: a valid input giving po=0101, then in_valid=0 for 3 cycles with random pi -> po stays 0101 and out_valid=0.
- Reset mid-stream: rst_n pulsed low during a valid burst -> outputs 0000; the first post-release valid input produces the correct sum after exactly 1 cycle.
